restador_serie: RTL and testbench

//  Bit-serial ripple subtractor. It computes d = a - b - bi one bit per clock,
//  LSB first, using a single full-subtractor cell. It is the inverse-arithmetic

---
 rtl/restador_serie_pkg.sv | 12 +
 rtl/restador_serie_if.sv | 17 +
 rtl/restador_completo.sv | 25 ++
 rtl/restador_serie.sv | 102 ++++++++++
 tb/tb_restador_serie.sv | 157 +++++++++++++++
 5 files changed

// File: rtl/restador_serie_pkg.sv
// Shared types and defaults for the bit-serial ripple subtractor.
package restador_serie_pkg;

  localparam int WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/restador_serie_if.sv
// Request/result bundle of the serial subtractor: operands in, difference out.
interface restador_serie_if #(
  parameter int WIDTH = restador_serie_pkg::WIDTH_DEF
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bi;
  logic             ready;
  logic             busy;
  logic [WIDTH-1:0] d;
  logic             bo;
  logic             valid;

  modport master (output start, a, b, bi, input ready, busy, d, bo, valid);
  modport slave  (input start, a, b, bi, output ready, busy, d, bo, valid);
endinterface

// File: rtl/restador_completo.sv
// 1-bit full subtractor: d = a ^ b ^ bi, bo = borrow of a - b - bi.
module restador_completo #(
  parameter int PwrC = 0
) (
  input  logic a_i,
  input  logic b_i,
  input  logic bi_i,
  output logic d_o,
  output logic bo_o
);

  // The tag picks the gate topology seen by the power flow; both are logically identical.
  if (PwrC == 0) begin : g_flat
    assign d_o  = a_i ^ b_i ^ bi_i;
    assign bo_o = (~a_i & b_i) | (~a_i & bi_i) | (b_i & bi_i);
  end else begin : g_half
    logic h_d, h_b1, h_b2;
    assign h_d  = a_i ^ b_i;
    assign h_b1 = ~a_i & b_i;
    assign h_b2 = ~h_d & bi_i;
    assign d_o  = h_d ^ bi_i;
    assign bo_o = h_b1 | h_b2;
  end

endmodule

// File: rtl/restador_serie.sv
// Bit-serial subtractor: d = a - b - bi, LSB first, one bit per clock through
// a single full-subtractor cell. One-cycle valid pulse when d/bo update.
module restador_serie
  import restador_serie_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int PwrC  = 0
) (
  input logic             clk,
  input logic             reset,
  restador_serie_if.slave bus
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d, b_sh_q, b_sh_d;
  logic [WIDTH-1:0] res_sh_q, res_sh_d, d_q, d_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             brw_q, brw_d, bo_q, bo_d, valid_q, valid_d;
  logic             diff, bout;

  restador_completo #(.PwrC(PwrC)) u_cell (
    .a_i (a_sh_q[0]),
    .b_i (b_sh_q[0]),
    .bi_i(brw_q),
    .d_o (diff),
    .bo_o(bout)
  );

  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    res_sh_d = res_sh_q;
    cnt_d    = cnt_q;
    brw_d    = brw_q;
    d_d      = d_q;
    bo_d     = bo_q;
    valid_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d  = S_SHIFT;
          a_sh_d   = bus.a;
          b_sh_d   = bus.b;
          brw_d    = bus.bi;
          cnt_d    = '0;
          res_sh_d = '0;
        end
      end
      S_SHIFT: begin
        brw_d    = bout;
        res_sh_d = {diff, res_sh_q[WIDTH-1:1]};
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        // Last bit: publish the result on the same edge so valid lines up with DONE.
        if (cnt_q == CNT_LAST) begin
          state_d = S_DONE;
          d_d     = res_sh_d;
          bo_d    = bout;
          valid_d = 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      res_sh_q <= '0;
      cnt_q    <= '0;
      brw_q    <= 1'b0;
      d_q      <= '0;
      bo_q     <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      res_sh_q <= res_sh_d;
      cnt_q    <= cnt_d;
      brw_q    <= brw_d;
      d_q      <= d_d;
      bo_q     <= bo_d;
      valid_q  <= valid_d;
    end
  end

  assign bus.ready = (state_q == S_IDLE);
  assign bus.busy  = (state_q == S_SHIFT);
  assign bus.d     = d_q;
  assign bus.bo    = bo_q;
  assign bus.valid = valid_q;

endmodule

// File: tb/tb_restador_serie.sv
// Directed and random checks of restador_serie against an integer-arithmetic model.
module tb_restador_serie;
  import restador_serie_pkg::*;

  localparam int W = 8;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  restador_serie_if #(.WIDTH(W)) bus ();
  restador_serie #(.WIDTH(W), .PwrC(0)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer subtraction, borrow = unsigned underflow.
  function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi);
    int r;
    r = int'(a) - int'(b) - int'(bi);
    return {1'b0, W'(r)} | {(r < 0), {W{1'b0}}};
  endfunction

  always @(negedge clk)
    if (reset === 1'b0) chk("ready_valid_overlap", 32'(bus.ready & bus.valid), 32'd0);

  task automatic randomize_inputs();
    bus.a  = W'($urandom);
    bus.b  = W'($urandom);
    bus.bi = 1'($urandom);
  endtask

  // One request with start pulsed; optional junk start during SHIFT.
  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic bi, input bit inject);
    logic [W:0] exp;
    bit early;
    exp = model(a, b, bi);
    @(negedge clk);
    chk({tag, "_ready"}, 32'(bus.ready), 32'd1);
    bus.a = a; bus.b = b; bus.bi = bi; bus.start = 1'b1;
    early = 1'b0;
    for (int i = 1; i <= W; i++) begin
      @(negedge clk);
      if (i == 1) chk({tag, "_busy"}, 32'(bus.busy), 32'd1);
      if (inject && i == 3) begin
        bus.start = 1'b1; bus.a = 8'hAA; bus.b = 8'h01; bus.bi = 1'b0;
      end else begin
        bus.start = 1'b0;
        randomize_inputs();
      end
      if (bus.valid === 1'b1) early = 1'b1;
    end
    @(negedge clk);
    chk({tag, "_early_valid"}, 32'(early), 32'd0);
    chk({tag, "_valid"}, 32'(bus.valid), 32'd1);
    chk({tag, "_d"}, 32'(bus.d), 32'(exp[W-1:0]));
    chk({tag, "_bo"}, 32'(bus.bo), 32'(exp[W]));
    chk({tag, "_ready_in_done"}, 32'(bus.ready), 32'd0);
    @(negedge clk);
    chk({tag, "_valid_drop"}, 32'(bus.valid), 32'd0);
    chk({tag, "_ready_back"}, 32'(bus.ready), 32'd1);
    chk({tag, "_d_hold"}, 32'(bus.d), 32'(exp[W-1:0]));
  endtask

  initial begin
    int cyc, prev_cyc;
    bit got, seen;
    logic [W:0] exp;

    reset = 1'b1;
    bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.bi = 1'b0;
    @(negedge clk);
    chk("rst_d", 32'(bus.d), 32'd0);
    chk("rst_bo", 32'(bus.bo), 32'd0);
    chk("rst_valid", 32'(bus.valid), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_ready", 32'(bus.ready), 32'd1);
    reset = 1'b0;

    run_op("t1", 8'h50, 8'h20, 1'b0, 1'b0);
    chk("t1_abs_d", 32'(bus.d), 32'h30);
    run_op("t2a", 8'h00, 8'h01, 1'b0, 1'b0);
    chk("t2a_abs", 32'({bus.bo, bus.d}), 32'h1FF);
    run_op("t2b", 8'hFF, 8'h00, 1'b0, 1'b0);
    chk("t2b_abs", 32'({bus.bo, bus.d}), 32'h0FF);
    run_op("t3a", 8'h10, 8'h10, 1'b1, 1'b0);
    chk("t3a_abs", 32'({bus.bo, bus.d}), 32'h1FF);
    run_op("t3b", 8'h10, 8'h0F, 1'b1, 1'b0);
    chk("t3b_abs", 32'({bus.bo, bus.d}), 32'h000);
    run_op("t4", 8'h50, 8'h20, 1'b0, 1'b1);
    chk("t4_abs_d", 32'(bus.d), 32'h30);
    @(negedge clk);
    chk("t4_no_restart", 32'(bus.busy), 32'd0);

    // Abort by reset in the middle of SHIFT.
    bus.a = 8'h50; bus.b = 8'h20; bus.bi = 1'b0; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    #2 reset = 1'b0;
    @(negedge clk);
    chk("t5_valid", 32'(bus.valid), 32'd0);
    chk("t5_d", 32'(bus.d), 32'd0);
    chk("t5_bo", 32'(bus.bo), 32'd0);
    chk("t5_ready", 32'(bus.ready), 32'd1);
    seen = 1'b0;
    repeat (W + 2) begin
      @(negedge clk);
      if (bus.valid === 1'b1) seen = 1'b1;
    end
    chk("t5_no_pulse", 32'(seen), 32'd0);
    run_op("t5_fresh", 8'hC3, 8'h5A, 1'b1, 1'b0);

    // Back-to-back random requests with start held high.
    cyc = 0; prev_cyc = 0;
    @(negedge clk);
    bus.start = 1'b1;
    for (int n = 0; n < 1000; n++) begin
      got = 1'b0;
      for (int k = 0; k < W + 4; k++) begin
        if (bus.ready === 1'b1) begin got = 1'b1; break; end
        @(negedge clk); cyc++;
      end
      if (!got) begin chk("b2b_ready_timeout", 32'(got), 32'd1); break; end
      randomize_inputs();
      exp = model(bus.a, bus.b, bus.bi);
      got = 1'b0;
      for (int k = 0; k < W + 4; k++) begin
        @(negedge clk); cyc++;
        if (bus.valid === 1'b1) begin got = 1'b1; break; end
        randomize_inputs();
      end
      if (!got) begin chk("b2b_valid_timeout", 32'(got), 32'd1); break; end
      chk("b2b_d", 32'(bus.d), 32'(exp[W-1:0]));
      chk("b2b_bo", 32'(bus.bo), 32'(exp[W]));
      if (n > 0) chk("b2b_spacing", 32'(cyc - prev_cyc), 32'(W + 2));
      prev_cyc = cyc;
      @(negedge clk); cyc++;
    end
    bus.start = 1'b0;
    repeat (2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
